dj_track_sequencer: RTL and testbench

- Parametrised successor to the fixed per-beat tone tables. Owns its own beat timebase, holds a writable per-channel note pattern, and plays it one-shot or looped.
- Outputs one 32-bit tone frequency per channel.
- Sits between the DJ control logic and the per-channel tone/PWM generators, replacing hard-coded beat-to-tone case tables.

---
 rtl/dj_track_sequencer_if.sv | 29 ++
 rtl/dj_track_sequencer.sv | 134 +++++++++++++
 tb/tb_dj_track_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dj_track_sequencer_if.sv
// Control, pattern-write and playback-status bundle between the DJ control logic
// and dj_track_sequencer.
interface dj_track_sequencer_if #(
  parameter int CH = 2,
  parameter int AW = 7
);
  logic             en;
  logic             pause;
  logic             loop;
  logic             restart;
  logic             wr_en;
  logic [7:0]       wr_ch;
  logic [AW-1:0]    wr_addr;
  logic [3:0]       wr_note;
  logic [AW-1:0]    beat_num;
  logic [CH*32-1:0] tone;
  logic             playing;
  logic             done;

  modport master (
    output en, pause, loop, restart, wr_en, wr_ch, wr_addr, wr_note,
    input  beat_num, tone, playing, done
  );

  modport slave (
    input  en, pause, loop, restart, wr_en, wr_ch, wr_addr, wr_note,
    output beat_num, tone, playing, done
  );
endinterface

// File: rtl/dj_track_sequencer.sv
// Per-channel note-pattern player with its own beat timebase; emits one tone
// frequency (Hz) per channel for the downstream tone/PWM generators.
//
// state  | meaning
// IDLE   | disabled, beat 0, divider 0, lanes silent
// PLAY   | divider running, beat advances on each tick
// PAUSED | divider and beat frozen, lanes silent
// DONE   | one-shot track finished, beat held at LEN-1
module dj_track_sequencer #(
  parameter int CH       = 2,
  parameter int LEN      = 92,
  parameter int AW       = 7,
  parameter int BEAT_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  dj_track_sequencer_if.slave   bus
);
  localparam logic [31:0] SIL = 32'd50000000;
  localparam int DW = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(BEAT_DIV - 1);
  localparam logic [AW-1:0] BEAT_LAST = AW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSED, DONE} state_t;

  state_t           state;
  logic [DW-1:0]    divider;
  logic [AW-1:0]    beat;
  logic [CH*32-1:0] tone_r;
  logic             playing_r;
  logic             done_r;
  logic             wr_ok;
  logic [CW-1:0]    wr_ch_idx;

  // Power-up contents of the pattern; rst deliberately leaves it alone.
  logic [3:0] pattern [CH][LEN] = '{default: '0};

  function automatic logic [31:0] note_freq(input logic [3:0] note);
    logic [31:0] f;
    case (note)
      4'd1:    f = 32'd262;
      4'd2:    f = 32'd392;
      4'd3:    f = 32'd494;
      4'd4:    f = 32'd524;
      4'd5:    f = 32'd588;
      4'd6:    f = 32'd660;
      4'd7:    f = 32'd698;
      4'd8:    f = 32'd784;
      default: f = SIL;
    endcase
    return f;
  endfunction

  assign wr_ch_idx = bus.wr_ch[CW-1:0];
  assign wr_ok     = bus.wr_en && (int'(bus.wr_ch) < CH) && (int'(bus.wr_addr) < LEN);

  always_ff @(posedge clk) begin
    if (wr_ok) pattern[wr_ch_idx][bus.wr_addr] <= bus.wr_note;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      divider   <= '0;
      tone_r    <= {CH{SIL}};
      playing_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // Lanes follow the state and beat held before this edge, one cycle behind.
      for (int k = 0; k < CH; k++)
        tone_r[32*k +: 32] <= (state == PLAY) ? note_freq(pattern[k][beat]) : SIL;

      if (!bus.en) begin
        state     <= IDLE;
        beat      <= '0;
        divider   <= '0;
        playing_r <= 1'b0;
      end else if (bus.restart) begin
        state     <= PLAY;
        beat      <= '0;
        divider   <= '0;
        playing_r <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= PLAY;
            beat      <= '0;
            divider   <= '0;
            playing_r <= 1'b1;
          end
          PLAY, PAUSED: begin
            if (bus.pause) begin
              state     <= PAUSED;
              playing_r <= 1'b0;
            end else begin
              // Leaving PAUSED counts this cycle, so the frozen partial beat resumes intact.
              state     <= PLAY;
              playing_r <= 1'b1;
              if (divider == DIV_LAST) begin
                divider <= '0;
                if (beat == BEAT_LAST) begin
                  done_r <= 1'b1;
                  if (bus.loop) begin
                    beat <= '0;
                  end else begin
                    state     <= DONE;
                    playing_r <= 1'b0;
                  end
                end else begin
                  beat <= beat + 1'b1;
                end
              end else begin
                divider <= divider + 1'b1;
              end
            end
          end
          DONE: state <= DONE;
          default: begin
            state     <= IDLE;
            playing_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.beat_num = beat;
  assign bus.tone     = tone_r;
  assign bus.playing  = playing_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_dj_track_sequencer.sv
// Directed table-driven bench for dj_track_sequencer with CH=2, LEN=4, BEAT_DIV=4.
module tb_dj_track_sequencer;
  localparam logic [31:0] SIL = 32'd50000000;

  typedef struct {
    logic        rst, en, loop, pause, restart, wr_en;
    logic [7:0]  wr_ch;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_note;
    int          n;
    logic [1:0]  beat;
    logic [31:0] l0, l1;
    logic        playing, done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dj_track_sequencer_if #(.CH(2), .AW(2)) bus ();

  dj_track_sequencer #(.CH(2), .LEN(4), .AW(2), .BEAT_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic       c_rst = 0, c_en = 0, c_loop = 0, c_pause = 0, c_restart = 0, c_wr_en = 0;
  logic [7:0] c_wr_ch = 0;
  logic [1:0] c_wr_addr = 0;
  logic [3:0] c_wr_note = 0;

  task automatic add(input int n, input logic [1:0] b, input logic [31:0] l0, input logic [31:0] l1,
                     input logic p, input logic d);
    vec_t v;
    v.rst = c_rst; v.en = c_en; v.loop = c_loop; v.pause = c_pause; v.restart = c_restart;
    v.wr_en = c_wr_en; v.wr_ch = c_wr_ch; v.wr_addr = c_wr_addr; v.wr_note = c_wr_note;
    v.n = n; v.beat = b; v.l0 = l0; v.l1 = l1; v.playing = p; v.done = d;
    vecs.push_back(v);
    c_rst = 0; c_restart = 0; c_wr_en = 0;
  endtask

  task automatic wr(input logic [7:0] ch, input logic [1:0] addr, input logic [3:0] note);
    c_wr_en = 1; c_wr_ch = ch; c_wr_addr = addr; c_wr_note = note;
  endtask

  // From IDLE with en=1 up to the last counting cycle of beat 3.
  task automatic play_to_beat3();
    add(1, 0, SIL, SIL, 1, 0);
    add(3, 0, 784, 524, 1, 0);
    add(1, 1, 784, 524, 1, 0);
    add(3, 1, 784, 588, 1, 0);
    add(1, 2, 784, 588, 1, 0);
    add(3, 2, SIL, 660, 1, 0);
    add(1, 3, SIL, 660, 1, 0);
    add(3, 3, 262, 698, 1, 0);
  endtask

  task automatic play_oneshot();
    play_to_beat3();
    add(1, 3, 262, 698, 0, 1);
    add(2, 3, SIL, SIL, 0, 0);
  endtask

  task automatic check(input int row, input int cyc, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL row%0d cyc%0d %s: got %0d want %0d", row, cyc, name, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then program ch0={8,8,0,1}, ch1={4,5,6,7} while idle.
    c_rst = 1; add(1, 0, SIL, SIL, 0, 0);
    wr(0, 0, 8); add(1, 0, SIL, SIL, 0, 0);
    wr(0, 1, 8); add(1, 0, SIL, SIL, 0, 0);
    wr(0, 2, 0); add(1, 0, SIL, SIL, 0, 0);
    wr(0, 3, 1); add(1, 0, SIL, SIL, 0, 0);
    wr(1, 0, 4); add(1, 0, SIL, SIL, 0, 0);
    wr(1, 1, 5); add(1, 0, SIL, SIL, 0, 0);
    wr(1, 2, 6); add(1, 0, SIL, SIL, 0, 0);
    wr(1, 3, 7); add(1, 0, SIL, SIL, 0, 0);
    c_en = 1; c_loop = 0; play_oneshot();

    // Looped play through a wrap, then pause two cycles into beat 1.
    c_en = 0; add(2, 0, SIL, SIL, 0, 0);
    c_en = 1; c_loop = 1; play_to_beat3();
    add(1, 0, 262, 698, 1, 1);
    add(3, 0, 784, 524, 1, 0);
    add(1, 1, 784, 524, 1, 0);
    add(2, 1, 784, 588, 1, 0);
    c_pause = 1; add(1, 1, 784, 588, 0, 0);
    add(9, 1, SIL, SIL, 0, 0);
    c_pause = 0; add(1, 1, SIL, SIL, 1, 0);
    add(1, 2, 784, 588, 1, 0);
    add(1, 2, SIL, 660, 1, 0);

    // Drop en at beat 2, then replay one-shot.
    c_en = 0; add(1, 0, SIL, 660, 0, 0);
    add(1, 0, SIL, SIL, 0, 0);
    c_en = 1; c_loop = 0; play_oneshot();

    // Restart from DONE, then rst at beat 2 and replay.
    c_restart = 1; add(1, 0, SIL, SIL, 1, 0);
    add(3, 0, 784, 524, 1, 0);
    add(1, 1, 784, 524, 1, 0);
    add(3, 1, 784, 588, 1, 0);
    add(1, 2, 784, 588, 1, 0);
    add(1, 2, SIL, 660, 1, 0);
    c_rst = 1; add(1, 0, SIL, SIL, 0, 0);
    play_oneshot();

    // Live write to the playing beat and out-of-range channel writes.
    c_restart = 1; add(1, 0, SIL, SIL, 1, 0);
    add(3, 0, 784, 524, 1, 0);
    add(1, 1, 784, 524, 1, 0);
    add(1, 1, 784, 588, 1, 0);
    wr(1, 1, 2); add(1, 1, 784, 588, 1, 0);
    add(1, 1, 784, 392, 1, 0);
    add(1, 2, 784, 392, 1, 0);
    add(1, 2, SIL, 660, 1, 0);
    wr(3, 3, 5); add(1, 2, SIL, 660, 1, 0);
    wr(2, 3, 5); add(1, 2, SIL, 660, 1, 0);
    add(1, 3, SIL, 660, 1, 0);
    add(1, 3, 262, 698, 1, 0);
    wr(8'hFF, 3, 5); add(1, 3, 262, 698, 1, 0);
    add(1, 3, 262, 698, 1, 0);
    add(1, 3, 262, 698, 0, 1);
    add(1, 3, SIL, SIL, 0, 0);

    rst = 1; bus.en = 0; bus.loop = 0; bus.pause = 0; bus.restart = 0;
    bus.wr_en = 0; bus.wr_ch = 0; bus.wr_addr = 0; bus.wr_note = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        rst         = (j == 0) && vecs[i].rst;
        bus.restart = (j == 0) && vecs[i].restart;
        bus.wr_en   = (j == 0) && vecs[i].wr_en;
        bus.en      = vecs[i].en;
        bus.loop    = vecs[i].loop;
        bus.pause   = vecs[i].pause;
        bus.wr_ch   = vecs[i].wr_ch;
        bus.wr_addr = vecs[i].wr_addr;
        bus.wr_note = vecs[i].wr_note;
        @(posedge clk);
        #1;
        check(i, j, "beat_num", 32'(bus.beat_num), 32'(vecs[i].beat));
        check(i, j, "tone0",    bus.tone[31:0],    vecs[i].l0);
        check(i, j, "tone1",    bus.tone[63:32],   vecs[i].l1);
        check(i, j, "playing",  32'(bus.playing),  32'(vecs[i].playing));
        check(i, j, "done",     32'(bus.done),     32'(vecs[i].done));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
